gigatron_input_tx: RTL

Host-side transmitter for the Gigatron input port. It emulates the serial game-controller link: a parallel-in/serial-out register in the controller and a serial-in/parallel-out register on the board. Both are clocked by the sync bits the `gigatron` core drives on `o_out`. A host hands it bytes over a valid/ready handshake, and it drives the core's `i_in` exactly as the real link would, one byte per video frame, with each byte held for a fixed number of frames.

---
 rtl/gigatron_input_tx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/gigatron_input_tx.sv
// Host-side transmitter emulating the Gigatron serial game-controller link.
// Bytes from a valid/ready host are shifted out MSB first on HSYNC and presented at VSYNC rise.
module gigatron_input_tx #(
  parameter int unsigned HOLD_FRAMES = 3,
  parameter logic [7:0]  IDLE_VALUE  = 8'hFF
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_out,
  output logic [7:0] o_in
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_GAP
  } state_e;

  logic [1:0] s_sync_q;
  logic [1:0] p_sync_q;
  logic       vfall;
  logic       vrise;
  logic       hrise;
  logic       sync_unused;

  state_e     state_q;
  state_e     state_d;
  logic [7:0] cur_q;
  logic [7:0] cur_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       ready_q;
  logic       accept;

  logic [7:0] tx_sh_q;
  logic [7:0] rx_sh_q;
  logic [3:0] bitcnt_q;
  logic [7:0] o_in_q;

  assign sync_unused = ^i_out[5:0];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      s_sync_q <= 2'b11;
      p_sync_q <= 2'b11;
    end else begin
      s_sync_q <= i_out[7:6];
      p_sync_q <= s_sync_q;
    end
  end

  assign vfall = p_sync_q[1] & ~s_sync_q[1];
  assign vrise = ~p_sync_q[1] & s_sync_q[1];
  assign hrise = ~p_sync_q[0] & s_sync_q[0];

  assign accept = i_valid & ready_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cur_d   = i_data;
          cnt_d   = 8'(HOLD_FRAMES);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (vfall) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            cur_d   = IDLE_VALUE;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (vfall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cur_q   <= IDLE_VALUE;
      cnt_q   <= 8'd0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  // Vertical edges win over a coincident HSYNC rise; bitcnt saturates at 8.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tx_sh_q  <= IDLE_VALUE;
      rx_sh_q  <= IDLE_VALUE;
      bitcnt_q <= 4'd8;
      o_in_q   <= IDLE_VALUE;
    end else if (vfall) begin
      tx_sh_q  <= cur_q;
      bitcnt_q <= 4'd0;
    end else if (vrise) begin
      o_in_q <= rx_sh_q;
    end else if (hrise && (bitcnt_q < 4'd8)) begin
      rx_sh_q  <= {rx_sh_q[6:0], tx_sh_q[7]};
      tx_sh_q  <= {tx_sh_q[6:0], 1'b1};
      bitcnt_q <= bitcnt_q + 4'd1;
    end
  end

  assign o_ready = ready_q;
  assign o_in    = o_in_q;

endmodule
